// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, ALU opcodes, and the
// operand-source and forwarding selectors used by the ID/EX stage.
package cpu_types_pkg;

   localparam int WORD_W_DEF = 32;
   localparam int REG_W_DEF  = 5;

   typedef logic [WORD_W_DEF-1:0] word_t;
   typedef logic [REG_W_DEF-1:0]  regbits_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } aluop_t;

   typedef enum logic [1:0] {
      SRC_REG   = 2'd0,
      SRC_SIMM  = 2'd1,
      SRC_ZIMM  = 2'd2,
      SRC_SHAMT = 2'd3
   } srcsel_t;

   typedef enum logic [1:0] {
      FWD_NONE  = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwdsel_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Combinational forwarding selector for one ALU source register.
// EX/MEM beats MEM/WB; register 0 is never forwarded.
module fwd_unit
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
) (
   input  logic [REG_W-1:0]  src_i,
   input  logic [WORD_W-1:0] rdat_i,
   input  logic              exmem_regwen_i,
   input  logic [REG_W-1:0]  exmem_rd_i,
   input  logic [WORD_W-1:0] exmem_result_i,
   input  logic              memwb_regwen_i,
   input  logic [REG_W-1:0]  memwb_rd_i,
   input  logic [WORD_W-1:0] memwb_wdat_i,
   output fwdsel_t           sel_o,
   output logic [WORD_W-1:0] data_o
);

   // Priority select of the freshest producer of src_i
   always_comb begin
      sel_o  = FWD_NONE;
      data_o = rdat_i;
      if (exmem_regwen_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i)) begin
         sel_o  = FWD_EXMEM;
         data_o = exmem_result_i;
      end else if (memwb_regwen_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i)) begin
         sel_o  = FWD_MEMWB;
         data_o = memwb_wdat_i;
      end else begin
         sel_o  = FWD_NONE;
         data_o = rdat_i;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, operand
// forwarding and ALU operand selection.
module id_ex_stage
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              id_valid,
   input  aluop_t            id_aluop,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [WORD_W-1:0] id_rdat1,
   input  logic [WORD_W-1:0] id_rdat2,
   input  logic [15:0]       id_imm16,
   input  logic [4:0]        id_shamt,
   input  srcsel_t           id_srcsel,
   input  logic              id_regwen,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              mem_stall,
   input  logic              flush,
   input  logic              exmem_regwen,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [WORD_W-1:0] exmem_result,
   input  logic              memwb_regwen,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic [WORD_W-1:0] memwb_wdat,
   output logic              id_stall,
   output logic              ex_valid,
   output aluop_t            ex_aluop,
   output logic [WORD_W-1:0] ex_input1,
   output logic [WORD_W-1:0] ex_input2,
   output logic [WORD_W-1:0] ex_storedata,
   output logic [REG_W-1:0]  ex_rd,
   output logic              ex_regwen,
   output logic              ex_memread,
   output logic              ex_memwrite
);

   logic              valid_q,    valid_d;
   aluop_t            aluop_q,    aluop_d;
   logic [REG_W-1:0]  rs_q,       rs_d;
   logic [REG_W-1:0]  rt_q,       rt_d;
   logic [REG_W-1:0]  rd_q,       rd_d;
   logic [WORD_W-1:0] rdat1_q,    rdat1_d;
   logic [WORD_W-1:0] rdat2_q,    rdat2_d;
   logic [15:0]       imm16_q,    imm16_d;
   logic [4:0]        shamt_q,    shamt_d;
   srcsel_t           srcsel_q,   srcsel_d;
   logic              regwen_q,   regwen_d;
   logic              memread_q,  memread_d;
   logic              memwrite_q, memwrite_d;

   logic              id_stall_s;
   fwdsel_t           rs_sel_s, rt_sel_s;
   logic [WORD_W-1:0] f_rs_s, f_rt_s;
   logic [3:0]        fwd_sel_unused_s;

   // The conservative rt compare also catches stores and I-type rt aliases
   assign id_stall_s = !mem_stall && id_valid && valid_q && memread_q &&
                       (rd_q != '0) && ((rd_q == id_rs) || (rd_q == id_rt));
   assign id_stall   = id_stall_s;

   // Next-state selection: freeze, bubble or capture
   always_comb begin
      valid_d    = valid_q;
      aluop_d    = aluop_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      rdat1_d    = rdat1_q;
      rdat2_d    = rdat2_q;
      imm16_d    = imm16_q;
      shamt_d    = shamt_q;
      srcsel_d   = srcsel_q;
      regwen_d   = regwen_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      if (mem_stall) begin
         valid_d = valid_q;
      end else if (flush || id_stall_s) begin
         valid_d    = 1'b0;
         aluop_d    = ALU_ADD;
         rs_d       = '0;
         rt_d       = '0;
         rd_d       = '0;
         rdat1_d    = '0;
         rdat2_d    = '0;
         imm16_d    = 16'h0000;
         shamt_d    = 5'd0;
         srcsel_d   = SRC_REG;
         regwen_d   = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
      end else begin
         valid_d    = id_valid;
         aluop_d    = id_aluop;
         rs_d       = id_rs;
         rt_d       = id_rt;
         rd_d       = id_rd;
         rdat1_d    = id_rdat1;
         rdat2_d    = id_rdat2;
         imm16_d    = id_imm16;
         shamt_d    = id_shamt;
         srcsel_d   = id_srcsel;
         regwen_d   = id_regwen;
         memread_d  = id_memread;
         memwrite_d = id_memwrite;
      end
   end

   // Pipeline register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q    <= 1'b0;
         aluop_q    <= ALU_ADD;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         rdat1_q    <= '0;
         rdat2_q    <= '0;
         imm16_q    <= 16'h0000;
         shamt_q    <= 5'd0;
         srcsel_q   <= SRC_REG;
         regwen_q   <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         aluop_q    <= aluop_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         rdat1_q    <= rdat1_d;
         rdat2_q    <= rdat2_d;
         imm16_q    <= imm16_d;
         shamt_q    <= shamt_d;
         srcsel_q   <= srcsel_d;
         regwen_q   <= regwen_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
      end
   end

   fwd_unit #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_rs (
      .src_i          (rs_q),
      .rdat_i         (rdat1_q),
      .exmem_regwen_i (exmem_regwen),
      .exmem_rd_i     (exmem_rd),
      .exmem_result_i (exmem_result),
      .memwb_regwen_i (memwb_regwen),
      .memwb_rd_i     (memwb_rd),
      .memwb_wdat_i   (memwb_wdat),
      .sel_o          (rs_sel_s),
      .data_o         (f_rs_s)
   );

   fwd_unit #(.WORD_W(WORD_W), .REG_W(REG_W)) u_fwd_rt (
      .src_i          (rt_q),
      .rdat_i         (rdat2_q),
      .exmem_regwen_i (exmem_regwen),
      .exmem_rd_i     (exmem_rd),
      .exmem_result_i (exmem_result),
      .memwb_regwen_i (memwb_regwen),
      .memwb_rd_i     (memwb_rd),
      .memwb_wdat_i   (memwb_wdat),
      .sel_o          (rt_sel_s),
      .data_o         (f_rt_s)
   );

   assign fwd_sel_unused_s = {rs_sel_s, rt_sel_s};

   // ALU operand select; shifts take the value from rt
   always_comb begin
      ex_input1 = f_rs_s;
      ex_input2 = f_rt_s;
      case (srcsel_q)
         SRC_REG: begin
            ex_input1 = f_rs_s;
            ex_input2 = f_rt_s;
         end
         SRC_SIMM: begin
            ex_input1 = f_rs_s;
            ex_input2 = {{(WORD_W-16){imm16_q[15]}}, imm16_q};
         end
         SRC_ZIMM: begin
            ex_input1 = f_rs_s;
            ex_input2 = {{(WORD_W-16){1'b0}}, imm16_q};
         end
         SRC_SHAMT: begin
            ex_input1 = f_rt_s;
            ex_input2 = {{(WORD_W-5){1'b0}}, shamt_q};
         end
         default: begin
            ex_input1 = f_rs_s;
            ex_input2 = f_rt_s;
         end
      endcase
   end

   assign ex_storedata = f_rt_s;
   assign ex_valid     = valid_q;
   assign ex_aluop     = aluop_q;
   assign ex_rd        = rd_q;
   assign ex_regwen    = regwen_q;
   assign ex_memread   = memread_q;
   assign ex_memwrite  = memwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: a vector table for capture, operand
// select and forwarding, plus sequences for reset, load-use, stall and flush.
module tb_id_ex_stage;
   import cpu_types_pkg::*;

   logic        CLK, RST;
   logic        id_valid;
   aluop_t      id_aluop;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rdat1, id_rdat2;
   logic [15:0] id_imm16;
   logic [4:0]  id_shamt;
   srcsel_t     id_srcsel;
   logic        id_regwen, id_memread, id_memwrite;
   logic        mem_stall, flush;
   logic        exmem_regwen, memwb_regwen;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_wdat;
   logic        id_stall, ex_valid, ex_regwen, ex_memread, ex_memwrite;
   aluop_t      ex_aluop;
   logic [31:0] ex_input1, ex_input2, ex_storedata;
   logic [4:0]  ex_rd;

   int tests = 0;
   int fails = 0;

   id_ex_stage dut (
      .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_aluop(id_aluop),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm16(id_imm16),
      .id_shamt(id_shamt), .id_srcsel(id_srcsel), .id_regwen(id_regwen),
      .id_memread(id_memread), .id_memwrite(id_memwrite),
      .mem_stall(mem_stall), .flush(flush),
      .exmem_regwen(exmem_regwen), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwen(memwb_regwen), .memwb_rd(memwb_rd), .memwb_wdat(memwb_wdat),
      .id_stall(id_stall), .ex_valid(ex_valid), .ex_aluop(ex_aluop),
      .ex_input1(ex_input1), .ex_input2(ex_input2), .ex_storedata(ex_storedata),
      .ex_rd(ex_rd), .ex_regwen(ex_regwen), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        v;
      logic [3:0]  op;
      logic [4:0]  rs, rt, rd;
      logic [31:0] r1, r2;
      logic [15:0] imm;
      logic [4:0]  sh;
      logic [1:0]  sel;
      logic        xw;
      logic [4:0]  xrd;
      logic [31:0] xres;
      logic        ww;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic [31:0] e1, e2, es;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [15:0] imm, input logic [4:0] sh, input logic [1:0] sel,
                        input logic rw, input logic mr, input logic mw);
      id_valid    = v;
      id_aluop    = aluop_t'(op);
      id_rs       = rs;
      id_rt       = rt;
      id_rd       = rd;
      id_rdat1    = r1;
      id_rdat2    = r2;
      id_imm16    = imm;
      id_shamt    = sh;
      id_srcsel   = srcsel_t'(sel);
      id_regwen   = rw;
      id_memread  = mr;
      id_memwrite = mw;
   endtask

   task automatic set_fwd(input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                          input logic ww, input logic [4:0] wrd, input logic [31:0] wdat);
      exmem_regwen = xw;
      exmem_rd     = xrd;
      exmem_result = xres;
      memwb_regwen = ww;
      memwb_rd     = wrd;
      memwb_wdat   = wdat;
   endtask

   initial begin
      //          v     op    rs    rt    rd    r1            r2            imm        sh    sel   xw    xrd   xres          ww    wrd   wdat          e1            e2            es
      vecs[0] = '{1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 32'd5,        32'd7,        16'h0000,  5'd0, 2'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'd5,        32'd7,        32'd7};
      vecs[1] = '{1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 32'd10,       32'd20,       16'hFFFC,  5'd0, 2'd1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'd10,       32'hFFFFFFFC, 32'd20};
      vecs[2] = '{1'b1, 4'd3, 5'd1, 5'd2, 5'd3, 32'd10,       32'd20,       16'hFFFC,  5'd0, 2'd2, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'd10,       32'h0000FFFC, 32'd20};
      vecs[3] = '{1'b1, 4'd8, 5'd0, 5'd2, 5'd3, 32'd99,       32'd1,        16'h0000,  5'd4, 2'd3, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'd1,        32'd4,        32'd1};
      vecs[4] = '{1'b1, 4'd0, 5'd4, 5'd5, 5'd6, 32'h100,      32'd9,        16'h0000,  5'd0, 2'd0, 1'b1, 5'd4, 32'hAA,       1'b1, 5'd4, 32'hBB,       32'hAA,       32'd9,        32'd9};
      vecs[5] = '{1'b1, 4'd0, 5'd4, 5'd5, 5'd6, 32'h100,      32'd9,        16'h0000,  5'd0, 2'd0, 1'b0, 5'd4, 32'hAA,       1'b1, 5'd4, 32'hBB,       32'hBB,       32'd9,        32'd9};
      vecs[6] = '{1'b1, 4'd1, 5'd0, 5'd0, 5'd6, 32'h123,      32'h77,       16'h0000,  5'd0, 2'd0, 1'b1, 5'd0, 32'hAA,       1'b1, 5'd0, 32'hBB,       32'h123,      32'h77,       32'h77};
      vecs[7] = '{1'b1, 4'd2, 5'd1, 5'd6, 5'd7, 32'd3,        32'd4,        16'h0000,  5'd0, 2'd0, 1'b1, 5'd9, 32'hDD,       1'b1, 5'd6, 32'hCC,       32'd3,        32'hCC,       32'hCC};
      vecs[8] = '{1'b1, 4'd9, 5'd1, 5'd7, 5'd8, 32'd3,        32'd4,        16'h0000,  5'd31,2'd3, 1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22,       32'h11,       32'd31,       32'h11};
      vecs[9] = '{1'b0, 4'd4, 5'd2, 5'd3, 5'd9, 32'hCAFE,     32'hBEEF,     16'h8000,  5'd0, 2'd1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'hCAFE,     32'hFFFF8000, 32'hBEEF};

      RST = 1'b1; mem_stall = 1'b0; flush = 1'b0;
      drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      #2;
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_aluop", {28'd0, ex_aluop}, 32'd0);
      check("rst_rd", {27'd0, ex_rd}, 32'd0);
      check("rst_ctrl", {29'd0, ex_regwen, ex_memread, ex_memwrite}, 32'd0);
      check("rst_in1", ex_input1, 32'd0);
      check("rst_in2", ex_input2, 32'd0);
      check("rst_store", ex_storedata, 32'd0);
      check("rst_stall", {31'd0, id_stall}, 32'd0);
      #1 RST = 1'b0;

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].r1, vecs[i].r2,
               vecs[i].imm, vecs[i].sh, vecs[i].sel, 1'b1, 1'b0, 1'b0);
         set_fwd(vecs[i].xw, vecs[i].xrd, vecs[i].xres, vecs[i].ww, vecs[i].wrd, vecs[i].wdat);
         step();
         check($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].v});
         check($sformatf("v%0d_aluop", i), {28'd0, ex_aluop}, {28'd0, vecs[i].op});
         check($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].rd});
         check($sformatf("v%0d_in1", i), ex_input1, vecs[i].e1);
         check($sformatf("v%0d_in2", i), ex_input2, vecs[i].e2);
         check($sformatf("v%0d_store", i), ex_storedata, vecs[i].es);
      end
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Load-use: LW r8 in EX, dependent op in ID
      drive(1'b1, 4'd0, 5'd1, 5'd8, 5'd8, 32'h1000, 32'h0, 16'h0004, 5'd0, 2'd1, 1'b1, 1'b1, 1'b0);
      step();
      check("lu_ld_memread", {31'd0, ex_memread}, 32'd1);
      drive(1'b1, 4'd0, 5'd8, 5'd2, 5'd9, 32'd1, 32'd2, 16'h0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      #1 check("lu_stall_rs", {31'd0, id_stall}, 32'd1);
      step();
      check("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
      check("lu_bubble_memread", {31'd0, ex_memread}, 32'd0);
      check("lu_bubble_rd", {27'd0, ex_rd}, 32'd0);
      check("lu_stall_clear", {31'd0, id_stall}, 32'd0);
      step();
      check("lu_capture_valid", {31'd0, ex_valid}, 32'd1);
      check("lu_capture_rd", {27'd0, ex_rd}, 32'd9);
      drive(1'b1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'd0, 16'h0, 5'd0, 2'd1, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, 4'd0, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 16'h0, 5'd0, 2'd1, 1'b1, 1'b1, 1'b0);
      #1 check("lu_r0_nostall", {31'd0, id_stall}, 32'd0);
      step();
      drive(1'b1, 4'd0, 5'd3, 5'd8, 5'd12, 32'd0, 32'd0, 16'h0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      #1 check("lu_stall_rt", {31'd0, id_stall}, 32'd1);
      step();
      step();
      check("lu_rt_capture_rd", {27'd0, ex_rd}, 32'd12);

      // mem_stall freeze
      drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd9, 32'h40, 32'h0, 16'h0008, 5'd0, 2'd1, 1'b1, 1'b1, 1'b0);
      step();
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2)
            drive(1'b1, 4'd1, 5'd10, 5'd11, 5'd20, 32'd50, 32'd8, 16'h0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
         else
            drive(1'b1, 4'd2, 5'd9, 5'd9, 5'd13 + 5'(i), 32'd1, 32'd1, 16'h0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
         #1 check($sformatf("ms%0d_stall", i), {31'd0, id_stall}, 32'd0);
         step();
         check($sformatf("ms%0d_rd", i), {27'd0, ex_rd}, 32'd9);
         check($sformatf("ms%0d_valid", i), {31'd0, ex_valid}, 32'd1);
         check($sformatf("ms%0d_memread", i), {31'd0, ex_memread}, 32'd1);
         check($sformatf("ms%0d_in1", i), ex_input1, 32'h40);
      end
      mem_stall = 1'b0;
      step();
      check("ms_release_rd", {27'd0, ex_rd}, 32'd20);
      check("ms_release_memread", {31'd0, ex_memread}, 32'd0);
      check("ms_release_in1", ex_input1, 32'd50);

      // flush
      drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2, 16'h0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
      flush = 1'b1;
      step();
      check("fl_valid", {31'd0, ex_valid}, 32'd0);
      check("fl_regwen", {31'd0, ex_regwen}, 32'd0);
      check("fl_memwrite", {31'd0, ex_memwrite}, 32'd0);
      flush = 1'b0;
      drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd6, 32'd1, 32'd2, 16'h0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step();
      check("fl_cap_rd", {27'd0, ex_rd}, 32'd6);
      flush = 1'b1; mem_stall = 1'b1;
      drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 16'h0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step();
      check("fl_ms_valid", {31'd0, ex_valid}, 32'd1);
      check("fl_ms_rd", {27'd0, ex_rd}, 32'd6);
      flush = 1'b0; mem_stall = 1'b0;

      // Asynchronous reset mid-cycle with a valid instruction in EX
      #3 RST = 1'b1;
      #1;
      check("mr_valid", {31'd0, ex_valid}, 32'd0);
      check("mr_regwen", {31'd0, ex_regwen}, 32'd0);
      check("mr_in1", ex_input1, 32'd0);
      RST = 1'b0;
      drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step();
      check("mr_cap_in1", ex_input1, 32'd5);
      check("mr_cap_in2", ex_input2, 32'd7);
      check("mr_cap_rd", {27'd0, ex_rd}, 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
